pe_row_db: RTL and testbench
============================

PE_ROW_DB -- requirements
Module: pe_row_db

Interface
REQ-001 SHALL have parameter NUM, default 16: number of PE columns in the row.
REQ-002 SHALL have parameter DW, default 8: signed weight/activation width.
REQ-003 SHALL have parameter ACCW, default 16: signed partial-sum width; ACCW >= 2*DW.
REQ-004 SHALL have port CLK  in  1  rising-edge clock; the block has one clock.
REQ-005 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port EN  in  1  global enable; 0 holds every register.
REQ-007 SHALL have port W_EN  in  1  weight shift enable.
REQ-008 SHALL have port SWAP  in  1  one-cycle pulse that promotes shadow weights to active.
REQ-009 SHALL have port in_weight_above  in  NUM*DW  weights from the row above; column i at [i*DW +: DW].
REQ-010 SHALL have port out_weight_below  out  NUM*DW  shadow weights passed to the row below.
REQ-011 SHALL have port act_left  in  DW  activation entering column 0.
REQ-012 SHALL have port act_valid_left  in  1  qualifies act_left.
REQ-013 SHALL have port act_right  out  DW  activation leaving column NUM-1.
REQ-014 SHALL have port act_valid_right  out  1  qualifies act_right.
REQ-015 SHALL have port in_sum  in  NUM*ACCW  partial sums from above.
REQ-016 SHALL have port out_sum  out  NUM*ACCW  registered partial sums.
REQ-017 SHALL have port out_valid  out  NUM  per-column out_sum valid.
REQ-018 SHALL have port bank_sel  out  1  active-bank indicator; toggles on each accepted SWAP.

Function
REQ-019 Every register SHALL update only on edges where EN=1.
REQ-020 With W_EN=1: shadow[i] SHALL take in_weight_above[i]; out_weight_below SHALL equal shadow, giving one cycle per row.
REQ-021 With SWAP=1: active[i] SHALL take the pre-edge shadow[i], even if W_EN=1 on the same edge.
REQ-022 With SWAP=1: bank_sel SHALL toggle.
REQ-023 The activation pipe SHALL be: a[0] registers act_left and act_valid_left; a[i] registers a[i-1] with its valid; act_right/act_valid_right = a[NUM-1].
REQ-024 An activation sampled at edge t0 SHALL reach a[i] after edge t0+i.
REQ-025 out_sum[i] SHALL update at edge t0+i+1 to sat(in_sum[i] + active[i]*a[i]), with in_sum[i] sampled at that edge.
REQ-026 The caller SHALL present in_sum[i] skewed to match REQ-025.
REQ-027 The product SHALL be signed 2*DW; the sum SHALL be formed at ACCW+1 bits and clamped to [-2^(ACCW-1), 2^(ACCW-1)-1].
REQ-028 out_valid[i] SHALL be the registered valid of a[i]; when that valid is 0, out_sum[i] SHALL hold its value.
REQ-029 If SWAP lands while valids are in flight, each column SHALL use the active weight present at its compute edge; no interlock SHALL exist.
REQ-030 W_EN and compute SHALL be independent: loading shadow SHALL NOT disturb active weights.

Reset
REQ-031 RESET_N=0 SHALL immediately clear shadow, active, the activation pipe, all valids, out_sum, out_weight_below and bank_sel to 0, regardless of CLK or EN.
REQ-032 Release of RESET_N SHALL be synchronised externally; the first active edge after release SHALL behave normally.

Structure
REQ-033 Shared package pe_pkg SHALL hold the default DW/ACCW constants and the saturation min/max function.
REQ-034 The row SHALL instantiate NUM copies of sub-module pe_cell: shadow/active weight, activation/valid register, saturating MAC, sum register.
REQ-035 pe_row_db SHALL only generate-chain the cells and own bank_sel.

Verification (NUM=4, DW=8, ACCW=16)
REQ-036 Reset: RESET_N low mid-stream -> all outputs 0 asynchronously; bank_sel=0.
REQ-037 Load/compute: W_EN one cycle with weights 3,4,5,6 -> out_weight_below=3,4,5,6 next edge; SWAP -> bank_sel=1. act 3 valid; skewed in_sum 1,2,3,4 -> out_sum 10,14,18,22 at t0+1..t0+4.
REQ-038 Double buffer: during a stream, load weights 1,1,1,1 into shadow -> results still use 3,4,5,6 until SWAP. Then act 2, in_sum 0 -> out_sum 2,2,2,2.
REQ-039 Saturation: w=-128, a=-128, in_sum=32767 -> 32767. w=127, a=-128, in_sum=-32768 -> -32768.
REQ-040 Stall: EN=0 for 3 cycles mid-stream -> all outputs frozen; after resume, sequence identical to the unstalled run, shifted 3 cycles.
REQ-041 Gaps: act_valid_left pattern 1,0,1 -> out_valid[i] replicates the pattern delayed i+1 cycles; out_sum held during the gap.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and the saturation helper for the PE systolic row.
package pe_pkg;

    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned ACCW_DEF = 16;

    typedef enum logic [1:0] {
        SatNone,
        SatMax,
        SatMin
    } sat_e;

    // carry is bit ACCW of the (ACCW+1)-bit sum, msb is bit ACCW-1; a mismatch means overflow.
    function automatic sat_e sat_kind(input logic carry, input logic msb);
        if (carry == msb) begin
            return SatNone;
        end
        return carry ? SatMin : SatMax;
    endfunction

endpackage

// File: rtl/pe_cell.sv
// One PE column: double-buffered weight, activation stage and saturating MAC
// feeding a held partial-sum register.
module pe_cell
    import pe_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            w_en,
    input  logic            swap,
    input  logic [DW-1:0]   weight_in,
    output logic [DW-1:0]   weight_out,
    input  logic [DW-1:0]   act_in,
    input  logic            act_valid_in,
    output logic [DW-1:0]   act_out,
    output logic            act_valid_out,
    input  logic [ACCW-1:0] sum_in,
    output logic [ACCW-1:0] sum_out,
    output logic            sum_valid
);

    logic [DW-1:0]   shadow_q;
    logic [DW-1:0]   active_q;
    logic [DW-1:0]   act_q;
    logic            act_valid_q;
    logic [ACCW-1:0] sum_q;
    logic            sum_valid_q;

    logic [2*DW-1:0] prod;
    logic [ACCW:0]   sum_wide;
    logic [ACCW-1:0] sum_d;

    // Operands sign-extended to 2*DW so the low 2*DW bits are the signed product.
    assign prod     = {{DW{active_q[DW-1]}}, active_q} * {{DW{act_q[DW-1]}}, act_q};
    assign sum_wide = {{(ACCW + 1 - 2 * DW){prod[2*DW-1]}}, prod} + {sum_in[ACCW-1], sum_in};

    always_comb begin
        sum_d = sum_wide[ACCW-1:0];
        unique case (sat_kind(sum_wide[ACCW], sum_wide[ACCW-1]))
            SatMax:  sum_d = {1'b0, {(ACCW - 1){1'b1}}};
            SatMin:  sum_d = {1'b1, {(ACCW - 1){1'b0}}};
            default: sum_d = sum_wide[ACCW-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            active_q    <= '0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else if (en) begin
            if (w_en) begin
                shadow_q <= weight_in;
            end
            // Promotes the pre-edge shadow even when a new weight loads on the same edge.
            if (swap) begin
                active_q <= shadow_q;
            end
            act_q       <= act_in;
            act_valid_q <= act_valid_in;
            sum_valid_q <= act_valid_q;
            if (act_valid_q) begin
                sum_q <= sum_d;
            end
        end
    end

    assign weight_out    = shadow_q;
    assign act_out       = act_q;
    assign act_valid_out = act_valid_q;
    assign sum_out       = sum_q;
    assign sum_valid     = sum_valid_q;

endmodule

// File: rtl/pe_row_db.sv
// Row of NUM PE cells with double-buffered weights; chains activations left to right
// and owns the active-bank indicator.
module pe_row_db
    import pe_pkg::*;
#(
    parameter int unsigned NUM  = 16,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned ACCW = ACCW_DEF
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                EN,
    input  logic                W_EN,
    input  logic                SWAP,
    input  logic [NUM*DW-1:0]   in_weight_above,
    output logic [NUM*DW-1:0]   out_weight_below,
    input  logic [DW-1:0]       act_left,
    input  logic                act_valid_left,
    output logic [DW-1:0]       act_right,
    output logic                act_valid_right,
    input  logic [NUM*ACCW-1:0] in_sum,
    output logic [NUM*ACCW-1:0] out_sum,
    output logic [NUM-1:0]      out_valid,
    output logic                bank_sel
);

    logic [NUM:0][DW-1:0] act_chain;
    logic [NUM:0]         vld_chain;
    logic                 bank_sel_q;

    assign act_chain[0] = act_left;
    assign vld_chain[0] = act_valid_left;

    for (genvar i = 0; i < NUM; i++) begin : g_cell
        pe_cell #(
            .DW   (DW),
            .ACCW (ACCW)
        ) u_cell (
            .clk           (CLK),
            .rst_n         (RESET_N),
            .en            (EN),
            .w_en          (W_EN),
            .swap          (SWAP),
            .weight_in     (in_weight_above[i*DW +: DW]),
            .weight_out    (out_weight_below[i*DW +: DW]),
            .act_in        (act_chain[i]),
            .act_valid_in  (vld_chain[i]),
            .act_out       (act_chain[i+1]),
            .act_valid_out (vld_chain[i+1]),
            .sum_in        (in_sum[i*ACCW +: ACCW]),
            .sum_out       (out_sum[i*ACCW +: ACCW]),
            .sum_valid     (out_valid[i])
        );
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bank_sel_q <= 1'b0;
        end else if (EN && SWAP) begin
            bank_sel_q <= ~bank_sel_q;
        end
    end

    assign act_right       = act_chain[NUM];
    assign act_valid_right = vld_chain[NUM];
    assign bank_sel        = bank_sel_q;

endmodule

// File: tb/tb_pe_row_db.sv
// Directed, table-driven bench for pe_row_db (NUM=4, DW=8, ACCW=16).
module tb_pe_row_db;

    localparam int NUM  = 4;
    localparam int DW   = 8;
    localparam int ACCW = 16;

    localparam logic [31:0] W3456 = 32'h0605_0403;
    localparam logic [31:0] W1    = 32'h0101_0101;
    localparam logic [31:0] WS    = 32'h0000_7F80;
    localparam logic [63:0] S1234 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] SSAT  = 64'h0000_0000_8000_7FFF;
    localparam logic [63:0] SQ    = 64'h0016_0012_000E_000A;
    localparam logic [63:0] S2    = 64'h0002_0002_0002_0002;
    localparam logic [63:0] S7    = 64'h0007_0007_0007_0007;
    localparam logic [63:0] S4    = 64'h0004_0004_0004_0004;
    localparam int NVEC = 42;

    logic                CLK = 1'b0;
    logic                RESET_N;
    logic                EN;
    logic                W_EN;
    logic                SWAP;
    logic [NUM*DW-1:0]   in_weight_above;
    logic [NUM*DW-1:0]   out_weight_below;
    logic [DW-1:0]       act_left;
    logic                act_valid_left;
    logic [DW-1:0]       act_right;
    logic                act_valid_right;
    logic [NUM*ACCW-1:0] in_sum;
    logic [NUM*ACCW-1:0] out_sum;
    logic [NUM-1:0]      out_valid;
    logic                bank_sel;

    pe_row_db #(
        .NUM  (NUM),
        .DW   (DW),
        .ACCW (ACCW)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .EN               (EN),
        .W_EN             (W_EN),
        .SWAP             (SWAP),
        .in_weight_above  (in_weight_above),
        .out_weight_below (out_weight_below),
        .act_left         (act_left),
        .act_valid_left   (act_valid_left),
        .act_right        (act_right),
        .act_valid_right  (act_valid_right),
        .in_sum           (in_sum),
        .out_sum          (out_sum),
        .out_valid        (out_valid),
        .bank_sel         (bank_sel)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        wen;
        logic        swap;
        logic [31:0] w;
        logic [7:0]  act;
        logic        av;
        logic [63:0] sum;
        logic [31:0] exp_wb;
        logic [63:0] exp_sum;
        logic [3:0]  exp_ov;
        logic        exp_bank;
        logic [7:0]  exp_ar;
        logic        exp_arv;
    } vec_t;

    vec_t tbl[NVEC];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic en, input logic wen, input logic swap,
                                input logic [31:0] w, input logic [7:0] act, input logic av,
                                input logic [63:0] sum, input logic [31:0] exp_wb,
                                input logic [63:0] exp_sum, input logic [3:0] exp_ov,
                                input logic exp_bank, input logic [7:0] exp_ar,
                                input logic exp_arv);
        vec_t v;
        v.en = en; v.wen = wen; v.swap = swap; v.w = w; v.act = act; v.av = av; v.sum = sum;
        v.exp_wb = exp_wb; v.exp_sum = exp_sum; v.exp_ov = exp_ov; v.exp_bank = exp_bank;
        v.exp_ar = exp_ar; v.exp_arv = exp_arv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] wb, input logic [63:0] sum,
                           input logic [3:0] ov, input logic bank, input logic [7:0] ar,
                           input logic arv);
        chk({tag, " out_weight_below"}, 64'(out_weight_below), 64'(wb));
        chk({tag, " out_sum"}, out_sum, sum);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, " bank_sel"}, 64'(bank_sel), 64'(bank));
        chk({tag, " act_right"}, 64'(act_right), 64'(ar));
        chk({tag, " act_valid_right"}, 64'(act_valid_right), 64'(arv));
    endtask

    initial begin
        // load / compute with weights 3,4,5,6 and constant in_sum 1,2,3,4
        tbl[0]  = mk(1, 1, 0, W3456, 8'h00, 0, S1234, W3456, 64'h0, 4'h0, 0, 8'h00, 0);
        tbl[1]  = mk(1, 0, 1, 32'h0, 8'h00, 0, S1234, W3456, 64'h0, 4'h0, 1, 8'h00, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0, 8'h03, 1, S1234, W3456, 64'h0, 4'h0, 1, 8'h00, 0);
        tbl[3]  = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W3456, 64'h000A, 4'h1, 1, 8'h00, 0);
        tbl[4]  = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W3456, 64'h000E_000A, 4'h2, 1, 8'h00, 0);
        tbl[5]  = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W3456, 64'h0012_000E_000A, 4'h4, 1,
                     8'h03, 1);
        tbl[6]  = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W3456, SQ, 4'h8, 1, 8'h00, 0);
        tbl[7]  = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W3456, SQ, 4'h0, 1, 8'h00, 0);
        // shadow loads 1s mid-stream; results keep using 3,4,5,6
        tbl[8]  = mk(1, 1, 0, W1, 8'h03, 1, S1234, W1, SQ, 4'h0, 1, 8'h00, 0);
        tbl[9]  = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W1, SQ, 4'h1, 1, 8'h00, 0);
        tbl[10] = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W1, SQ, 4'h2, 1, 8'h00, 0);
        tbl[11] = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W1, SQ, 4'h4, 1, 8'h03, 1);
        tbl[12] = mk(1, 0, 0, 32'h0, 8'h00, 0, S1234, W1, SQ, 4'h8, 1, 8'h00, 0);
        tbl[13] = mk(1, 0, 1, 32'h0, 8'h00, 0, S1234, W1, SQ, 4'h0, 0, 8'h00, 0);
        tbl[14] = mk(1, 0, 0, 32'h0, 8'h02, 1, 64'h0, W1, SQ, 4'h0, 0, 8'h00, 0);
        tbl[15] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0016_0012_000E_0002, 4'h1, 0,
                     8'h00, 0);
        tbl[16] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0016_0012_0002_0002, 4'h2, 0,
                     8'h00, 0);
        tbl[17] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0016_0002_0002_0002, 4'h4, 0,
                     8'h02, 1);
        tbl[18] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, S2, 4'h8, 0, 8'h00, 0);
        // valid pattern 1,0,1 with a gap in the middle
        tbl[19] = mk(1, 0, 0, 32'h0, 8'h05, 1, 64'h0, W1, S2, 4'h0, 0, 8'h00, 0);
        tbl[20] = mk(1, 0, 0, 32'h0, 8'h09, 0, 64'h0, W1, 64'h0002_0002_0002_0005, 4'h1, 0,
                     8'h00, 0);
        tbl[21] = mk(1, 0, 0, 32'h0, 8'h07, 1, 64'h0, W1, 64'h0002_0002_0005_0005, 4'h2, 0,
                     8'h00, 0);
        tbl[22] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0002_0005_0005_0007, 4'h5, 0,
                     8'h05, 1);
        tbl[23] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0005_0005_0007_0007, 4'hA, 0,
                     8'h09, 0);
        tbl[24] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0005_0007_0007_0007, 4'h4, 0,
                     8'h07, 1);
        tbl[25] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, S7, 4'h8, 0, 8'h00, 0);
        tbl[26] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, S7, 4'h0, 0, 8'h00, 0);
        // three-cycle stall with an activation in flight; W_EN/SWAP ignored while EN=0
        tbl[27] = mk(1, 0, 0, 32'h0, 8'h04, 1, 64'h0, W1, S7, 4'h0, 0, 8'h00, 0);
        tbl[28] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0007_0007_0007_0004, 4'h1, 0,
                     8'h00, 0);
        tbl[29] = mk(0, 1, 1, 32'h7F7F_7F7F, 8'h09, 1, 64'h1111_2222_3333_4444, W1,
                     64'h0007_0007_0007_0004, 4'h1, 0, 8'h00, 0);
        tbl[30] = mk(0, 0, 0, 32'h0, 8'h09, 1, 64'h1111_2222_3333_4444, W1,
                     64'h0007_0007_0007_0004, 4'h1, 0, 8'h00, 0);
        tbl[31] = mk(0, 0, 1, 32'h0, 8'h09, 1, 64'h1111_2222_3333_4444, W1,
                     64'h0007_0007_0007_0004, 4'h1, 0, 8'h00, 0);
        tbl[32] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0007_0007_0004_0004, 4'h2, 0,
                     8'h00, 0);
        tbl[33] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, 64'h0007_0004_0004_0004, 4'h4, 0,
                     8'h04, 1);
        tbl[34] = mk(1, 0, 0, 32'h0, 8'h00, 0, 64'h0, W1, S4, 4'h8, 0, 8'h00, 0);
        // saturation: col0 w=-128, col1 w=127, a=-128
        tbl[35] = mk(1, 1, 0, WS, 8'h00, 0, 64'h0, WS, S4, 4'h0, 0, 8'h00, 0);
        tbl[36] = mk(1, 0, 1, 32'h0, 8'h00, 0, 64'h0, WS, S4, 4'h0, 1, 8'h00, 0);
        tbl[37] = mk(1, 0, 0, 32'h0, 8'h80, 1, SSAT, WS, S4, 4'h0, 1, 8'h00, 0);
        tbl[38] = mk(1, 0, 0, 32'h0, 8'h00, 0, SSAT, WS, 64'h0004_0004_0004_7FFF, 4'h1, 1,
                     8'h00, 0);
        tbl[39] = mk(1, 0, 0, 32'h0, 8'h00, 0, SSAT, WS, 64'h0004_0004_8000_7FFF, 4'h2, 1,
                     8'h00, 0);
        tbl[40] = mk(1, 0, 0, 32'h0, 8'h00, 0, SSAT, WS, 64'h0004_0000_8000_7FFF, 4'h4, 1,
                     8'h80, 1);
        tbl[41] = mk(1, 0, 0, 32'h0, 8'h00, 0, SSAT, WS, SSAT, 4'h8, 1, 8'h00, 0);

        RESET_N         = 1'b0;
        EN              = 1'b0;
        W_EN            = 1'b0;
        SWAP            = 1'b0;
        in_weight_above = '0;
        act_left        = '0;
        act_valid_left  = 1'b0;
        in_sum          = '0;
        #12;
        chk_all("reset", 32'h0, 64'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        RESET_N = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            EN              = tbl[i].en;
            W_EN            = tbl[i].wen;
            SWAP            = tbl[i].swap;
            in_weight_above = tbl[i].w;
            act_left        = tbl[i].act;
            act_valid_left  = tbl[i].av;
            in_sum          = tbl[i].sum;
            @(posedge CLK);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].exp_wb, tbl[i].exp_sum, tbl[i].exp_ov,
                    tbl[i].exp_bank, tbl[i].exp_ar, tbl[i].exp_arv);
        end

        // Mid-stream asynchronous reset, asserted between clock edges
        EN             = 1'b1;
        act_left       = 8'h06;
        act_valid_left = 1'b1;
        in_sum         = S1234;
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 64'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        @(posedge CLK);
        #1;
        chk_all("reset_held", 32'h0, 64'h0, 4'h0, 1'b0, 8'h00, 1'b0);

        // First edge after release behaves normally
        @(negedge CLK);
        RESET_N         = 1'b1;
        W_EN            = 1'b1;
        SWAP            = 1'b1;
        in_weight_above = 32'h0202_0202;
        act_left        = 8'h00;
        act_valid_left  = 1'b0;
        @(posedge CLK);
        #1;
        chk_all("post_reset", 32'h0202_0202, 64'h0, 4'h0, 1'b1, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
